lif_update_scheduler: RTL and testbench

Time-multiplexed leaky-integrate-and-fire update controller. It shares one `decay_potential` datapath among `N_NEURON` membrane potentials held in an internal register file. On each timestep it walks every neuron in index order: decay, integrate the streamed input current, threshold, and spike/reset. It sits between the timestep generator and the spike router.

---
 rtl/snn_pkg.sv | 20 ++
 rtl/decay_potential.sv | 20 ++
 rtl/lif_update_scheduler.sv | 118 +++++++++++
 tb/tb_lif_update_scheduler.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-neuron update path: scheduler FSM
// states, potential width derivation and the saturation ceiling.
package snn_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DECAY = 2'd1,
      INTEG = 2'd2,
      DONE  = 2'd3
   } sched_state_e;

   // Potential width follows the decay datapath depth.
   function automatic int pot_w(input int n_stage);
      return n_stage + 2;
   endfunction

   // All-ones source for the saturation ceiling; users keep the low W bits.
   localparam logic [31:0] SAT_ALL_ONES = 32'hFFFF_FFFF;

endpackage

// File: rtl/decay_potential.sv
// Leak step of the membrane potential: beta = u - (u >> shift).
// shift = 0 removes the whole potential (full leak); any other shift keeps
// beta <= u, so the subtraction can never underflow.
module decay_potential
   import snn_pkg::*;
#(
   parameter  int N_STAGE = 10,
   localparam int W       = pot_w(N_STAGE)
) (
   input  logic [W-1:0] u,
   input  logic [2:0]   shift,
   output logic [W-1:0] beta
);

   // Leak by a power-of-two fraction of the current potential.
   always_comb begin
      beta = u - (u >> shift);
   end

endmodule

// File: rtl/lif_update_scheduler.sv
// Time-multiplexed LIF update controller. One timestep walks neurons 0..N-1:
// decay the stored potential, add the streamed current (saturating),
// compare with the threshold, then either spike-and-reset or store the sum.
// Current handshake: a transfer happens on a rising edge where cur_ready and
// cur_valid are both high; cur_ready only rises in INTEG and cur_data must be
// stable while cur_valid is high and unaccepted.
module lif_update_scheduler
   import snn_pkg::*;
#(
   parameter  int N_NEURON = 8,
   parameter  int N_STAGE  = 10,
   localparam int IDX_W    = $clog2(N_NEURON),
   localparam int W        = pot_w(N_STAGE)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             clear_pot,
   input  logic [2:0]       shift,
   input  logic [W-1:0]     threshold,
   input  logic             cur_valid,
   output logic             cur_ready,
   input  logic [W-1:0]     cur_data,
   output logic [IDX_W-1:0] cur_idx,
   output logic             spike_valid,
   output logic [IDX_W-1:0] spike_idx,
   output logic             busy,
   output logic             done,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [W-1:0]     rd_data,
   output sched_state_e     dbg_state
);

   localparam logic [W-1:0] SAT_MAX = SAT_ALL_ONES[W-1:0];

   sched_state_e     state, state_d;
   logic [IDX_W-1:0] idx;
   logic [2:0]       shift_q;
   logic [W-1:0]     threshold_q;
   logic [W-1:0]     beta_q, beta_d;
   logic [W-1:0]     pot [N_NEURON];
   logic [W:0]       sum_raw;
   logic [W-1:0]     sum_sat;
   logic             hs, last, fire, accept_start;

   decay_potential #(.N_STAGE(N_STAGE)) u_decay (
      .u     (pot[idx]),
      .shift (shift_q),
      .beta  (beta_d)
   );

   assign accept_start = (state == IDLE) && start;
   assign hs           = (state == INTEG) && cur_valid;
   assign last         = (idx == IDX_W'(N_NEURON - 1));
   assign sum_raw      = {1'b0, beta_q} + {1'b0, cur_data};
   assign sum_sat      = sum_raw[W] ? SAT_MAX : sum_raw[W-1:0];
   assign fire         = (sum_sat >= threshold_q);

   assign cur_ready = (state == INTEG);
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign cur_idx   = idx;
   assign rd_data   = pot[rd_idx];
   assign dbg_state = state;

   // Next-state logic: INTEG holds until the current handshake.
   always_comb begin
      state_d = state;
      unique case (state)
         IDLE:    if (start) state_d = DECAY;
         DECAY:   state_d = INTEG;
         INTEG:   if (cur_valid) state_d = last ? DONE : DECAY;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Control registers: state, neuron index, latched parameters, spike pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         idx         <= '0;
         shift_q     <= '0;
         threshold_q <= '0;
         beta_q      <= '0;
         spike_valid <= 1'b0;
         spike_idx   <= '0;
      end else begin
         state       <= state_d;
         spike_valid <= 1'b0;
         if (accept_start) begin
            shift_q     <= shift;
            threshold_q <= threshold;
            idx         <= '0;
         end
         if (state == DECAY) beta_q <= beta_d;
         if (hs) begin
            if (fire) begin
               spike_valid <= 1'b1;
               spike_idx   <= idx;
            end
            if (!last) idx <= idx + 1'b1;
         end
      end
   end

   // Potential register file: bulk clear from IDLE, one write per handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_NEURON; i++) pot[i] <= '0;
      end else if ((state == IDLE) && !start && clear_pot) begin
         for (int i = 0; i < N_NEURON; i++) pot[i] <= '0;
      end else if (hs) begin
         pot[idx] <= fire ? '0 : sum_sat;
      end
   end

endmodule

// File: tb/tb_lif_update_scheduler.sv
// Directed bench for lif_update_scheduler. Expected spikes and done cycles
// are queued when a timestep is issued; a monitor pops them as the DUT
// reports. Potentials after each timestep are checked against hand values.
module tb_lif_update_scheduler;
   import snn_pkg::*;

   localparam int N     = 8;
   localparam int W     = 12;
   localparam int IDX_W = 3;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic             clear_pot = 1'b0;
   logic [2:0]       shift = '0;
   logic [W-1:0]     threshold = '0;
   logic             cur_valid = 1'b0;
   logic             cur_ready;
   logic [W-1:0]     cur_data = '0;
   logic [IDX_W-1:0] cur_idx;
   logic             spike_valid;
   logic [IDX_W-1:0] spike_idx;
   logic             busy;
   logic             done;
   logic [IDX_W-1:0] rd_idx = '0;
   logic [W-1:0]     rd_data;
   sched_state_e     dbg_state;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int e0 = 0;

   logic [IDX_W-1:0] exp_q[$];
   int               exp_done_q[$];
   logic [W-1:0]     cur_tab [N];
   logic [W-1:0]     pot_tab [N];

   lif_update_scheduler #(.N_NEURON(N), .N_STAGE(10)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .clear_pot   (clear_pot),
      .shift       (shift),
      .threshold   (threshold),
      .cur_valid   (cur_valid),
      .cur_ready   (cur_ready),
      .cur_data    (cur_data),
      .cur_idx     (cur_idx),
      .spike_valid (spike_valid),
      .spike_idx   (spike_idx),
      .busy        (busy),
      .done        (done),
      .rd_idx      (rd_idx),
      .rd_data     (rd_data),
      .dbg_state   (dbg_state)
   );

   // Clock and cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Scoreboard monitor: spikes and done pulses against queued expectations
   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         if (spike_valid) begin
            if (exp_q.size() == 0) chk("spike_unexpected", 32'(spike_idx) + 1, 0);
            else chk("spike_idx", 32'(spike_idx), 32'(exp_q.pop_front()));
         end
         if (done) begin
            if (exp_done_q.size() == 0) chk("done_unexpected", 1, 0);
            else chk("done_cycle", cyc - e0 + 1, exp_done_q.pop_front());
         end
      end
   end

   // One current handshake for neuron i (cur_valid stays high afterwards)
   task automatic hs(input int i);
      bit ok = 0;
      cur_valid = 1'b1;
      cur_data  = cur_tab[i];
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (cur_ready) begin
            chk("cur_idx", 32'(cur_idx), i);
            chk("busy_run", 32'(busy), 1);
            @(posedge clk);
            #1;
            ok = 1;
            break;
         end
      end
      if (!ok) chk("handshake_timeout", 0, 1);
   endtask

   task automatic check_pots(input string name);
      for (int i = 0; i < N; i++) begin
         rd_idx = IDX_W'(i);
         #1;
         chk(name, 32'(rd_data), 32'(pot_tab[i]));
      end
   endtask

   // Issue one timestep; pot_tab holds the expected potentials afterwards
   task automatic run_step(input logic [2:0] s, input logic [W-1:0] thr,
                           input logic [N-1:0] mask, input int hold_idx,
                           input int hold_n, input logic [W-1:0] hold_pot,
                           input int exp_done, input bit with_clear, input bit poke);
      bit ok = 0;
      for (int i = 0; i < N; i++) if (mask[i]) exp_q.push_back(IDX_W'(i));
      exp_done_q.push_back(exp_done);
      shift     = s;
      threshold = thr;
      clear_pot = with_clear;
      cur_valid = 1'b0;
      rd_idx    = IDX_W'(hold_idx < 0 ? 0 : hold_idx);
      start     = 1'b1;
      @(posedge clk);
      #1;
      e0        = cyc;
      start     = 1'b0;
      clear_pot = 1'b0;
      fork
         begin
            for (int i = 0; i < N; i++) begin
               if (i == hold_idx) begin
                  int cnt = 0;
                  cur_valid = 1'b0;
                  for (int t = 0; t < 50 && cnt < hold_n; t++) begin
                     @(negedge clk);
                     if (cur_ready) begin
                        chk("hold_state", 32'(dbg_state), 32'(INTEG));
                        chk("hold_nowrite", 32'(rd_data), 32'(hold_pot));
                        cnt++;
                     end
                  end
                  @(posedge clk);
                  #1;
               end
               hs(i);
            end
         end
         begin
            if (poke) begin
               repeat (3) @(posedge clk);
               #1;
               start     = 1'b1;
               clear_pot = 1'b1;
               repeat (3) @(posedge clk);
               #1;
               start     = 1'b0;
               clear_pot = 1'b0;
            end
         end
      join
      cur_valid = 1'b0;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (dbg_state == IDLE) begin
            ok = 1;
            break;
         end
      end
      if (!ok) chk("idle_timeout", 0, 1);
      chk("busy_idle", 32'(busy), 0);
      check_pots("pot");
   endtask

   initial begin
      // Reset state
      #12;
      chk("rst_cur_ready", 32'(cur_ready), 0);
      chk("rst_spike_valid", 32'(spike_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_cur_idx", 32'(cur_idx), 0);
      chk("rst_spike_idx", 32'(spike_idx), 0);
      chk("rst_state", 32'(dbg_state), 32'(IDLE));
      pot_tab = '{default: '0};
      check_pots("rst_pot");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // A: preload pot0=800, pot5=50 with full leak; cur_valid always high
      cur_tab = '{12'd800, 0, 0, 0, 0, 12'd50, 0, 0};
      pot_tab = '{12'd800, 0, 0, 0, 0, 12'd50, 0, 0};
      run_step(3'd0, 12'd4095, 8'h00, -1, 0, 0, 17, 0, 0);

      // B: shift 2: 800->600+100=700, 50->38
      cur_tab = '{12'd100, 0, 0, 0, 0, 0, 0, 0};
      pot_tab = '{12'd700, 0, 0, 0, 0, 12'd38, 0, 0};
      run_step(3'd2, 12'd1000, 8'h00, -1, 0, 0, 17, 0, 0);

      // C: 700->525+500=1025 spikes; neuron 7 hits threshold exactly
      cur_tab = '{12'd500, 0, 0, 0, 0, 0, 0, 12'd1000};
      pot_tab = '{12'd0, 0, 0, 0, 0, 12'd29, 0, 12'd0};
      run_step(3'd2, 12'd1000, 8'h81, -1, 0, 0, 17, 0, 0);

      // D: preload pot0=4000, pot3=1234
      cur_tab = '{12'd4000, 0, 0, 12'd1234, 0, 0, 0, 0};
      pot_tab = '{12'd4000, 0, 0, 12'd1234, 0, 0, 0, 0};
      run_step(3'd0, 12'd4095, 8'h00, -1, 0, 0, 17, 0, 0);

      // E: saturation 3969+500 -> 4095 spikes; 4094 just below threshold
      cur_tab = '{12'd500, 12'd4094, 0, 0, 0, 0, 0, 0};
      pot_tab = '{12'd0, 12'd4094, 0, 12'd1225, 0, 0, 0, 0};
      run_step(3'd7, 12'd4095, 8'h01, -1, 0, 0, 17, 0, 0);

      // F: full leak with 5 cycles of backpressure on neuron 3
      cur_tab = '{0, 0, 0, 12'd7, 0, 0, 0, 0};
      pot_tab = '{0, 0, 0, 12'd7, 0, 0, 0, 0};
      run_step(3'd0, 12'd4095, 8'h00, 3, 5, 12'd1225, 22, 0, 0);

      // G: threshold 0 makes every neuron spike
      cur_tab = '{12'd1, 12'd2, 12'd3, 12'd4, 12'd5, 12'd6, 12'd7, 12'd8};
      pot_tab = '{default: '0};
      run_step(3'd1, 12'd0, 8'hFF, -1, 0, 0, 17, 0, 0);

      // H: start and clear_pot pulses during busy are ignored
      cur_tab = '{12'd10, 12'd20, 12'd30, 12'd40, 12'd50, 12'd60, 12'd70, 12'd80};
      pot_tab = '{12'd10, 12'd20, 12'd30, 12'd40, 12'd50, 12'd60, 12'd70, 12'd80};
      run_step(3'd1, 12'd4095, 8'h00, -1, 0, 0, 17, 0, 1);

      // H2: start wins over clear_pot; shift 1 halves each potential
      cur_tab = '{default: '0};
      pot_tab = '{12'd5, 12'd10, 12'd15, 12'd20, 12'd25, 12'd30, 12'd35, 12'd40};
      run_step(3'd1, 12'd4095, 8'h00, -1, 0, 0, 17, 1, 0);

      // clear_pot in IDLE zeroes everything
      clear_pot = 1'b1;
      @(posedge clk);
      #1;
      clear_pot = 1'b0;
      @(negedge clk);
      chk("clear_state", 32'(dbg_state), 32'(IDLE));
      pot_tab = '{default: '0};
      check_pots("clear_pot");

      // Reset while neuron 3 is in progress
      cur_tab   = '{default: 12'd9};
      shift     = 3'd0;
      threshold = 12'd4095;
      start     = 1'b1;
      @(posedge clk);
      #1;
      e0    = cyc;
      start = 1'b0;
      for (int i = 0; i < 3; i++) hs(i);
      @(negedge clk);
      chk("abort_idx", 32'(cur_idx), 3);
      rst_n = 1'b0;
      #1;
      cur_valid = 1'b0;
      chk("abort_cur_ready", 32'(cur_ready), 0);
      chk("abort_spike_valid", 32'(spike_valid), 0);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_done", 32'(done), 0);
      chk("abort_cur_idx", 32'(cur_idx), 0);
      chk("abort_spike_idx", 32'(spike_idx), 0);
      check_pots("abort_pot");
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("abort_stays_idle", 32'(dbg_state), 32'(IDLE));

      // Fresh timestep after abort begins at neuron 0
      cur_tab = '{12'd1, 12'd2, 12'd3, 12'd4, 12'd5, 12'd6, 12'd7, 12'd8};
      pot_tab = '{12'd1, 12'd2, 12'd3, 12'd4, 12'd5, 12'd6, 12'd7, 12'd8};
      run_step(3'd0, 12'd4095, 8'h00, -1, 0, 0, 17, 0, 0);

      repeat (4) @(negedge clk);
      chk("spikes_left", exp_q.size(), 0);
      chk("dones_left", exp_done_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
